// File: rtl/vga_dvd_decoder_if.sv
// Video-in / decode-result bundle between a TinyVGA source and the decoder.
// Latency: none, wires only.
// Backpressure: none; the pixel stream and result pulse are free-running.
interface vga_dvd_decoder_if;
    logic [7:0] vga_in;
    logic [4:0] dvd_x;
    logic [3:0] dvd_y;
    logic [5:0] fg_rgb;
    logic       result_valid;
    logic       locked;
    logic       timing_err;
    logic       blank_err;
    logic       decode_err;

    // Video source side: drives the PMOD byte, observes the decode result.
    modport master (
        output vga_in,
        input  dvd_x, dvd_y, fg_rgb, result_valid, locked,
        input  timing_err, blank_err, decode_err
    );

    // Decoder side.
    modport slave (
        input  vga_in,
        output dvd_x, dvd_y, fg_rgb, result_valid, locked,
        output timing_err, blank_err, decode_err
    );
endinterface

// File: rtl/vga_dvd_decoder.sv
// Recovers the bouncing-target cell and colour from a TinyVGA PMOD pixel stream.
// Latency: result_valid two clocks after the registered vsync fall is first seen.
// Backpressure: none; pixels are consumed every clock, results are one-cycle pulses.
module vga_dvd_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int V_ACT_START = 35,
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_dvd_decoder_if.slave   bus
);
    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [9:0]  H_ST    = 10'(H_ACT_START);
    localparam logic [9:0]  H_EN    = 10'(H_ACT_START + H_ACT);
    localparam logic [9:0]  V_ST    = 10'(V_ACT_START);
    localparam logic [9:0]  V_EN    = 10'(V_ACT_START + V_ACT);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LINES = 10'(V_TOTAL);
    // A target is one full 32x32 cell; a target parked at (0,0) is seen as
    // "everything else differs from the first pixel".
    localparam logic [18:0] MM_TGT  = 19'd1024;
    localparam logic [18:0] MM_BG   = 19'(H_ACT * V_ACT - 1024);
    localparam logic [4:0]  CX_LIM  = 5'(H_ACT / 32);
    localparam logic [3:0]  CY_LIM  = 4'(V_ACT / 32);

    logic [7:0]  in_q, in_qq;
    logic [9:0]  hcnt, lcnt;
    logic        h_seen, v_seen;
    logic [5:0]  c0;
    logic        c0_vld;
    logic [18:0] mm_cnt;
    logic [4:0]  fm_x;
    logic [3:0]  fm_y;
    logic        multi, match_out, tflag, bflag;
    logic        ev_pend, ev_ok, ev_terr, ev_berr;
    logic [4:0]  ev_x, dvd_x_q;
    logic [3:0]  ev_y, dvd_y_q;
    logic [5:0]  ev_rgb, fg_rgb_q;
    logic        result_valid_q, locked_q, timing_err_q, blank_err_q, decode_err_q;

    // Edges are seen between the input register and its delayed copy, so the
    // colour in in_qq lines up with hcnt/lcnt on the same cycle.
    logic       hs_fall, vs_fall, vis, is_origin, h_bad, v_bad, tgt_ok, bg_ok;
    logic [5:0] rgb;
    logic [9:0] px_x, px_y;
    logic [4:0] cell_x;
    logic [3:0] cell_y;

    assign hs_fall   = in_qq[7] & ~in_q[7];
    assign vs_fall   = in_qq[3] & ~in_q[3];
    assign rgb       = {in_qq[0], in_qq[4], in_qq[1], in_qq[5], in_qq[2], in_qq[6]};
    assign vis       = (hcnt >= H_ST) && (hcnt < H_EN) && (lcnt >= V_ST) && (lcnt < V_EN);
    assign px_x      = hcnt - H_ST;
    assign px_y      = lcnt - V_ST;
    assign cell_x    = 5'(px_x >> 5);
    assign cell_y    = 4'(px_y >> 5);
    assign is_origin = (hcnt == H_ST) && (lcnt == V_ST);
    // No reference before the first hsync after reset, so that interval is not judged.
    assign h_bad     = hs_fall & h_seen & (hcnt != H_LAST);
    // An hsync fall coinciding with vsync loses its increment to the lcnt reload.
    assign v_bad     = (lcnt + {9'd0, hs_fall}) != V_LINES;
    assign tgt_ok    = c0_vld && (mm_cnt == MM_TGT) && !multi &&
                       (fm_x < CX_LIM) && (fm_y < CY_LIM);
    assign bg_ok     = c0_vld && (mm_cnt == MM_BG) && !match_out;

    // Input pipeline and raster counters; vsync reload wins over the hsync increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= 8'h88;
            in_qq  <= 8'h88;
            hcnt   <= '0;
            lcnt   <= '0;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
        end else begin
            in_q  <= bus.vga_in;
            in_qq <= in_q;
            if (hs_fall)
                hcnt <= '0;
            else if (hcnt != CNT_MAX)
                hcnt <= hcnt + 10'd1;
            if (vs_fall)
                lcnt <= '0;
            else if (hs_fall && lcnt != CNT_MAX)
                lcnt <= lcnt + 10'd1;
            if (hs_fall)
                h_seen <= 1'b1;
            if (vs_fall)
                v_seen <= 1'b1;
        end
    end

    // Per-frame pixel statistics; wiped on every vsync fall once evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0 <= '0; c0_vld <= 1'b0; mm_cnt <= '0; fm_x <= '0; fm_y <= '0;
            multi <= 1'b0; match_out <= 1'b0; tflag <= 1'b0; bflag <= 1'b0;
        end else if (vs_fall) begin
            c0 <= '0; c0_vld <= 1'b0; mm_cnt <= '0; fm_x <= '0; fm_y <= '0;
            multi <= 1'b0; match_out <= 1'b0; tflag <= 1'b0; bflag <= 1'b0;
        end else begin
            if (h_bad)
                tflag <= 1'b1;
            if (vis) begin
                if (is_origin) begin
                    c0     <= rgb;
                    c0_vld <= 1'b1;
                end else if (c0_vld) begin
                    if (rgb != c0) begin
                        if (mm_cnt != '1)
                            mm_cnt <= mm_cnt + 19'd1;
                        if (mm_cnt == '0) begin
                            fm_x <= cell_x;
                            fm_y <= cell_y;
                        end else if (cell_x != fm_x || cell_y != fm_y || rgb != ~c0) begin
                            multi <= 1'b1;
                        end
                    end else if (cell_x != 5'd0 || cell_y != 4'd0) begin
                        match_out <= 1'b1;
                    end
                end
            end else if (rgb != 6'd0) begin
                bflag <= 1'b1;
            end
        end
    end

    // Frame verdict captured on the vsync-fall cycle, including that cycle's checks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_pend <= 1'b0; ev_ok <= 1'b0; ev_terr <= 1'b0; ev_berr <= 1'b0;
            ev_x <= '0; ev_y <= '0; ev_rgb <= '0;
        end else begin
            ev_pend <= vs_fall;
            if (vs_fall) begin
                ev_ok   <= tgt_ok | bg_ok;
                ev_terr <= tflag | ~v_seen | h_bad | v_bad;
                ev_berr <= bflag;
                ev_x    <= tgt_ok ? fm_x : 5'd0;
                ev_y    <= tgt_ok ? fm_y : 4'd0;
                ev_rgb  <= tgt_ok ? ~c0 : c0;
            end
        end
    end

    // Publish the verdict; target outputs hold their last good value on a failed decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid_q <= 1'b0; locked_q <= 1'b0; timing_err_q <= 1'b0;
            blank_err_q <= 1'b0; decode_err_q <= 1'b0;
            dvd_x_q <= '0; dvd_y_q <= '0; fg_rgb_q <= '0;
        end else begin
            result_valid_q <= ev_pend;
            if (ev_pend) begin
                timing_err_q <= ev_terr;
                blank_err_q  <= ev_berr;
                decode_err_q <= ~ev_ok;
                locked_q     <= ~ev_terr;
                if (ev_ok) begin
                    dvd_x_q  <= ev_x;
                    dvd_y_q  <= ev_y;
                    fg_rgb_q <= ev_rgb;
                end
            end
        end
    end

    assign bus.dvd_x        = dvd_x_q;
    assign bus.dvd_y        = dvd_y_q;
    assign bus.fg_rgb       = fg_rgb_q;
    assign bus.result_valid = result_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timing_err   = timing_err_q;
    assign bus.blank_err    = blank_err_q;
    assign bus.decode_err   = decode_err_q;
endmodule

// File: tb/tb_vga_dvd_decoder.sv
// Frame-level bench: a compact raster (2x2 cells) exercises every decode path.
// Latency: results checked once per generated frame.
// Backpressure: none; the source drives a pixel every clock.
module tb_vga_dvd_decoder;
    localparam int HT = 72, VT = 67, HA = 64, VA = 64;
    localparam int HS_ST = 66, HS_LEN = 4, VS_LINE = 65;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_dvd_decoder_if bus();

    vga_dvd_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(6), .V_ACT_START(2),
        .H_ACT(HA), .V_ACT(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        int         tx0, ty0, tx1, ty1;
        logic [5:0] bg, fg;
        int         short_line, blank_line, rst_line;
        bit         chk_all;
        int         ex, ey;
        logic [5:0] ergb;
        bit         elock, eterr, eberr, ederr;
    } frame_t;

    frame_t tbl [9];
    int total = 0;
    int bad   = 0;
    int res_cnt;
    int r_x, r_y, r_rgb, r_lock, r_terr, r_berr, r_derr;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic frame_t mk(input int tx0, input int ty0, input int tx1, input int ty1,
                                  input logic [5:0] bg, input logic [5:0] fg,
                                  input int sl, input int bl, input int rl, input bit ca,
                                  input int ex, input int ey, input logic [5:0] ergb,
                                  input bit el, input bit et, input bit eb, input bit ed);
        frame_t t;
        t.tx0 = tx0; t.ty0 = ty0; t.tx1 = tx1; t.ty1 = ty1;
        t.bg = bg; t.fg = fg;
        t.short_line = sl; t.blank_line = bl; t.rst_line = rl; t.chk_all = ca;
        t.ex = ex; t.ey = ey; t.ergb = ergb;
        t.elock = el; t.eterr = et; t.eberr = eb; t.ederr = ed;
        return t;
    endfunction

    function automatic logic [7:0] vga_byte(input bit hs, input bit vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dvd_x"},        int'(bus.dvd_x), 0);
        check({tag, "_dvd_y"},        int'(bus.dvd_y), 0);
        check({tag, "_fg_rgb"},       int'(bus.fg_rgb), 0);
        check({tag, "_result_valid"}, int'(bus.result_valid), 0);
        check({tag, "_locked"},       int'(bus.locked), 0);
        check({tag, "_timing_err"},   int'(bus.timing_err), 0);
        check({tag, "_blank_err"},    int'(bus.blank_err), 0);
        check({tag, "_decode_err"},   int'(bus.decode_err), 0);
    endtask

    task automatic run_frame(input int f);
        frame_t t;
        int len, cx, cy;
        bit hs, vs;
        logic [5:0] c;
        t = tbl[f];
        res_cnt = 0;
        r_x = -1; r_y = -1; r_rgb = -1; r_lock = -1; r_terr = -1; r_berr = -1; r_derr = -1;
        for (int v = 0; v < VT; v++) begin
            len = (v == t.short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                c = 6'd0;
                if (h < HA && v < VA) begin
                    cx = h / 32;
                    cy = v / 32;
                    if ((cx == t.tx0 && cy == t.ty0) || (cx == t.tx1 && cy == t.ty1))
                        c = t.fg;
                    else
                        c = t.bg;
                end else if (v == t.blank_line && h == HA + 1) begin
                    c = 6'b000001;
                end
                hs = !(h >= HS_ST && h < HS_ST + HS_LEN);
                vs = (v != VS_LINE);
                @(negedge clk);
                if (bus.result_valid) begin
                    res_cnt++;
                    r_x = int'(bus.dvd_x); r_y = int'(bus.dvd_y); r_rgb = int'(bus.fg_rgb);
                    r_lock = int'(bus.locked); r_terr = int'(bus.timing_err);
                    r_berr = int'(bus.blank_err); r_derr = int'(bus.decode_err);
                end
                bus.vga_in = vga_byte(hs, vs, c);
                if (v == t.rst_line && h == 0) begin
                    #1 rst_n = 1'b0;
                    #1 check_reset_outputs($sformatf("f%0d_midrst", f));
                end
                if (v == t.rst_line && h == 2)
                    rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        //            targets         bg         fg        short blank rst chk  x  y  rgb        lk te be de
        tbl[0] = mk(1, 1, -1, -1, 6'b001111, 6'b110000, -1, -1, -1, 0, 0, 0, 6'b000000, 0, 1, 0, 0);
        tbl[1] = mk(1, 1, -1, -1, 6'b001111, 6'b110000, -1, -1, -1, 1, 1, 1, 6'b110000, 1, 0, 0, 0);
        tbl[2] = mk(0, 0, -1, -1, 6'b110000, 6'b001111, -1, -1, -1, 1, 0, 0, 6'b001111, 1, 0, 0, 0);
        tbl[3] = mk(1, 1, -1, -1, 6'b001111, 6'b110000, 63, -1, -1, 1, 1, 1, 6'b110000, 0, 1, 0, 0);
        tbl[4] = mk(1, 0, -1, -1, 6'b001111, 6'b110000, -1, 10, -1, 1, 1, 0, 6'b110000, 1, 0, 1, 0);
        tbl[5] = mk(1, 0, -1, -1, 6'b001111, 6'b110000, -1, -1, -1, 1, 1, 0, 6'b110000, 1, 0, 0, 0);
        tbl[6] = mk(0, 1,  1,  1, 6'b001111, 6'b110000, -1, -1, -1, 1, 1, 0, 6'b110000, 1, 0, 0, 1);
        tbl[7] = mk(0, 1, -1, -1, 6'b001111, 6'b110000, -1, -1, 30, 0, 0, 0, 6'b000000, 0, 1, 0, 0);
        tbl[8] = mk(0, 1, -1, -1, 6'b001111, 6'b110000, -1, -1, -1, 1, 0, 1, 6'b110000, 1, 0, 0, 0);

        rst_n = 1'b0;
        bus.vga_in = vga_byte(1'b1, 1'b1, 6'd0);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int f = 0; f < 9; f++) begin
            run_frame(f);
            check($sformatf("f%0d_result_pulses", f), res_cnt, 1);
            check($sformatf("f%0d_timing_err", f), r_terr, int'(tbl[f].eterr));
            check($sformatf("f%0d_locked", f), r_lock, int'(tbl[f].elock));
            if (tbl[f].chk_all) begin
                check($sformatf("f%0d_dvd_x", f), r_x, tbl[f].ex);
                check($sformatf("f%0d_dvd_y", f), r_y, tbl[f].ey);
                check($sformatf("f%0d_fg_rgb", f), r_rgb, int'(tbl[f].ergb));
                check($sformatf("f%0d_blank_err", f), r_berr, int'(tbl[f].eberr));
                check($sformatf("f%0d_decode_err", f), r_derr, int'(tbl[f].ederr));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_dvd_decoder.md
VGA_DVD_DECODER -- requirements
Module: vga_dvd_decoder

Interface
REQ-001 Parameter H_TOTAL, 800, clocks per line; the hsync falling-edge interval SHALL equal this value.
REQ-002 Parameter V_TOTAL, 525, lines per frame; the vsync falling-edge interval SHALL equal this value in lines.
REQ-003 Parameter H_ACT_START, 144, clocks from hsync fall to visible x=0; 640 visible pixels.
REQ-004 Parameter V_ACT_START, 35, line count after vsync fall at which visible y=0; 480 visible lines.
REQ-005 clk  input  1  pixel clock; single clock domain.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 vga_in  input  8  TinyVGA PMOD byte {hsync,B0,G0,R0,vsync,B1,G1,R1}; sync signals active-low.
REQ-008 dvd_x  output  5  decoded target cell column (pixel x>>5), 0..19.
REQ-009 dvd_y  output  4  decoded target cell row (pixel y>>5), 0..14.
REQ-010 fg_rgb  output  6  target colour {R1,R0,G1,G0,B1,B0}.
REQ-011 result_valid  output  1  one-cycle pulse; new frame result presented.
REQ-012 locked  output  1  sync timing verified for the last complete frame.
REQ-013 timing_err, blank_err, decode_err  output  1 each  sticky-per-frame error flags, updated with result_valid.

Function
REQ-014 vga_in SHALL be registered once; edges are detected between that register and a second delayed copy; a transition sampled at edge N is acted on at edge N+1.
REQ-015 On an hsync falling edge hcnt SHALL load 0; otherwise it increments, saturating at 1023; hcnt=0 corresponds to transmitter hpos 656.
REQ-016 On a vsync falling edge lcnt SHALL load 0; on each hsync falling edge lcnt increments (10 bits, saturating at 1023).
REQ-017 A pixel is visible when H_ACT_START <= hcnt < H_ACT_START+640 and V_ACT_START <= lcnt < V_ACT_START+480; x = hcnt-H_ACT_START, y = lcnt-V_ACT_START.
REQ-018 Colour decode: R={vga_in[0],vga_in[4]}, G={vga_in[1],vga_in[5]}, B={vga_in[2],vga_in[6]}.
REQ-019 Visible pixel (0,0) colour SHALL be latched as c0; every later visible pixel with colour != c0 is a mismatch.
REQ-020 19-bit mismatch counter; cell of first mismatch latched; any later mismatch in a different cell, or with colour != ~c0, sets a frame-local multi flag.
REQ-021 Any non-visible sample with RGB != 0 SHALL set frame-local blank flag.
REQ-022 An hsync interval != H_TOTAL, or a vsync interval != V_TOTAL lines, SHALL set frame-local timing flag; the first vsync fall after reset sets it (no prior reference).
REQ-023 Frame evaluation on each vsync falling edge (edge N+1): mismatch count 1024, no multi -> target = first-mismatch cell, fg_rgb = ~c0; count 306176 with all matches in cell (0,0) -> target (0,0), fg_rgb = c0; else decode_err.
REQ-024 result_valid SHALL pulse one cycle at edge N+2; dvd_x/dvd_y/fg_rgb update only when decode succeeds, else hold.
REQ-025 Cell result outside 0..19 / 0..14 SHALL be decode_err.
REQ-026 locked SHALL set at result_valid when timing flag clear; clear at result_valid when set.
REQ-027 All frame-local flags, counters and c0 SHALL clear at each vsync falling edge after evaluation.
REQ-028 Simultaneous hsync and vsync falling edges: vsync action SHALL take priority for lcnt (load 0).

Reset
REQ-029 rst_n low SHALL asynchronously clear all state: dvd_x=0, dvd_y=0, fg_rgb=0, result_valid=0, locked=0, all error flags=0, hcnt=lcnt=0.
REQ-030 Reset deassertion mid-frame: first partial frame SHALL report timing_err=1 and locked=0; the next clean frame reports normally.

Verification
REQ-031 Reset, then two clean frames from a reference 640x480 generator with target at cell (5,3), ui colour 6'b110000 -> second result_valid: dvd_x=5, dvd_y=3, fg_rgb=6'b110000, locked=1, all errors 0.
REQ-032 Clean frames with target at cell (0,0), colour 6'b001111 -> dvd_x=0, dvd_y=0, fg_rgb=6'b001111, decode_err=0.
REQ-033 One line with hsync period 799 clocks -> that frame: timing_err=1, locked=0; next clean frame restores locked=1.
REQ-034 RGB=6'b000001 during one horizontal-blanking clock -> blank_err=1 for that frame only; target still decoded.
REQ-035 Two target cells (2,2) and (9,9) in one frame -> decode_err=1, dvd_x/dvd_y hold prior values.
REQ-036 rst_n pulsed low mid-frame -> outputs at reset values immediately; behaviour per REQ-030.
